// File: rtl/banco_registros_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | banco_registros_param : 2R/1W register file, x0 hardwired, write bypass,   |
// |                         self-clearing after reset or on request            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module banco_registros_param #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int NUM_REGS   = 32,
    parameter int INIT_INDEX = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] Add_A,
    input  logic [ADDR_W-1:0] Add_B,
    input  logic [ADDR_W-1:0] Add_Dest,
    input  logic [DATA_W-1:0] Write_Data,
    input  logic              Write_En,
    input  logic              Clear_Req,
    output logic [DATA_W-1:0] Info_A,
    output logic [DATA_W-1:0] Info_B,
    output logic              Busy
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W:0]   NUM_EXT  = (ADDR_W + 1)'(NUM_REGS);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   ptr;
    logic [ADDR_W-1:0]   ptr_nxt;
    logic                clr_we;
    logic [DATA_W-1:0]   clr_data;
    logic                wr_act;
    logic [DATA_W-1:0]   a_nxt;
    logic [DATA_W-1:0]   b_nxt;
    logic [DATA_W-1:0]   regs [NUM_REGS];

    // Address 0 and anything beyond the implemented entries read as zero
    function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
        return (addr != '0) && ({1'b0, addr} < NUM_EXT);
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        clr_we    = 1'b0;
        case (state)
            ST_CLEAR: begin
                clr_we = 1'b1;
                if (ptr == LAST_PTR) begin
                    state_nxt = ST_RUN;
                    ptr_nxt   = '0;
                end else begin
                    ptr_nxt = ptr + ADDR_W'(1);
                end
            end
            ST_RUN: begin
                if (Clear_Req) begin
                    state_nxt = ST_CLEAR;
                    ptr_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_CLEAR;
                ptr_nxt   = '0;
            end
        endcase
    end

    assign clr_data = (INIT_INDEX != 0) ? DATA_W'(ptr) : '0;
    assign wr_act   = (state == ST_RUN) && !Clear_Req && Write_En && addr_ok(Add_Dest);
    assign Busy     = (state == ST_CLEAR);

    // Storage carries no reset; the clear sequencer initialises it
    always_ff @(posedge CLK) begin
        if (clr_we) begin
            regs[ptr[IDX_W-1:0]] <= clr_data;
        end else if (wr_act) begin
            regs[Add_Dest[IDX_W-1:0]] <= Write_Data;
        end
    end

    always_comb begin
        a_nxt = '0;
        b_nxt = '0;
        if (state == ST_RUN) begin
            if (addr_ok(Add_A)) begin
                a_nxt = (wr_act && (Add_Dest == Add_A)) ? Write_Data : regs[Add_A[IDX_W-1:0]];
            end
            if (addr_ok(Add_B)) begin
                b_nxt = (wr_act && (Add_Dest == Add_B)) ? Write_Data : regs[Add_B[IDX_W-1:0]];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Info_A <= '0;
            Info_B <= '0;
        end else begin
            Info_A <= a_nxt;
            Info_B <= b_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_banco_registros_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_banco_registros_param : directed + randomized bench against a model     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_banco_registros_param;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int NUM_REGS   = 16;
    localparam int INIT_INDEX = 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [ADDR_W-1:0] add_a = '0;
    logic [ADDR_W-1:0] add_b = '0;
    logic [ADDR_W-1:0] add_dest = '0;
    logic [DATA_W-1:0] write_data = '0;
    logic              write_en = 1'b0;
    logic              clear_req = 1'b0;
    logic [DATA_W-1:0] info_a;
    logic [DATA_W-1:0] info_b;
    logic              busy;

    banco_registros_param #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .NUM_REGS  (NUM_REGS),
        .INIT_INDEX(INIT_INDEX)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .Add_A     (add_a),
        .Add_B     (add_b),
        .Add_Dest  (add_dest),
        .Write_Data(write_data),
        .Write_En  (write_en),
        .Clear_Req (clear_req),
        .Info_A    (info_a),
        .Info_B    (info_b),
        .Busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Reference model: array contents plus number of clear edges still owed
    logic [DATA_W-1:0] mem [NUM_REGS];
    int                clear_left = NUM_REGS;
    logic [DATA_W-1:0] exp_a = '0;
    logic [DATA_W-1:0] exp_b = '0;
    int                m_idx;
    bit                m_wr;

    function automatic logic [DATA_W-1:0] model_read(input int addr, input bit wr,
                                                     input int dest, input logic [DATA_W-1:0] data);
        if (addr == 0 || addr >= NUM_REGS) return '0;
        if (wr && dest == addr) return data;
        return mem[addr];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            clear_left = NUM_REGS;
            exp_a = '0;
            exp_b = '0;
        end else if (clear_left > 0) begin
            m_idx = NUM_REGS - clear_left;
            mem[m_idx] = (INIT_INDEX != 0) ? DATA_W'(m_idx) : '0;
            clear_left = clear_left - 1;
            exp_a = '0;
            exp_b = '0;
        end else begin
            m_wr = write_en && !clear_req && (int'(add_dest) != 0) && (int'(add_dest) < NUM_REGS);
            exp_a = model_read(int'(add_a), m_wr, int'(add_dest), write_data);
            exp_b = model_read(int'(add_b), m_wr, int'(add_dest), write_data);
            if (m_wr) mem[int'(add_dest)] = write_data;
            if (clear_req) clear_left = NUM_REGS;
        end
    end

    task automatic compare(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            compare("cyc_info_a", info_a, exp_a);
            compare("cyc_info_b", info_b, exp_b);
            compare("cyc_busy", {31'b0, busy}, (clear_left > 0) ? 32'd1 : 32'd0);
        end
    end

    task automatic cyc(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                       input logic [ADDR_W-1:0] dest, input logic [DATA_W-1:0] data,
                       input logic we, input logic cr);
        add_a = a;
        add_b = b;
        add_dest = dest;
        write_data = data;
        write_en = we;
        clear_req = cr;
        @(negedge clk);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    int n;

    initial begin
        @(negedge clk);
        #1 rst = 1'b1;
        check_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        // Write and clear request during the clear must both be dropped
        add_a = 5'd3; add_b = 5'd3; add_dest = 5'd3;
        write_data = 32'hAA; write_en = 1'b1; clear_req = 1'b1;
        count_busy(n);
        compare("reset_clear_len", n, 32'd16);

        cyc(5'd3, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
        compare("drop_write_3", info_a, 32'd3);
        compare("read_x0_b", info_b, 32'd0);
        cyc(5'd5, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
        compare("init_5", info_a, 32'd5);

        cyc(5'd0, 5'd0, 5'd0, 32'hDEADBEEF, 1'b1, 1'b0);
        compare("x0_wr_a", info_a, 32'd0);
        compare("x0_wr_b", info_b, 32'd0);
        cyc(5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
        compare("x0_rd_a", info_a, 32'd0);
        compare("x0_rd_b", info_b, 32'd0);

        cyc(5'd7, 5'd7, 5'd7, 32'h12345678, 1'b1, 1'b0);
        compare("bypass_a", info_a, 32'h12345678);
        compare("bypass_b", info_b, 32'h12345678);
        compare("model_bypass", exp_a, 32'h12345678);
        cyc(5'd7, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
        compare("after_bypass", info_a, 32'h12345678);

        cyc(5'd20, 5'd20, 5'd20, 32'h55, 1'b1, 1'b0);
        compare("oor_same_cyc", info_a, 32'd0);
        cyc(5'd20, 5'd4, 5'd0, 32'h0, 1'b0, 1'b0);
        compare("oor_read", info_a, 32'd0);
        compare("oor_no_alias", info_b, 32'd4);

        cyc(5'd0, 5'd0, 5'd9, 32'h99, 1'b1, 1'b0);
        cyc(5'd9, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
        compare("wr_9", info_a, 32'h99);

        cyc(5'd9, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1);
        compare("clr_req_busy", {31'b0, busy}, 32'd1);
        compare("clr_req_info", info_a, 32'h99);
        count_busy(n);
        compare("clr_req_len", n, 32'd16);
        cyc(5'd9, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
        compare("clr_9", info_a, 32'd9);
        compare("model_clr_9", exp_a, 32'd9);

        cyc(5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1);
        repeat (9) cyc(5'd1, 5'd2, 5'd1, 32'h1, 1'b1, 1'b0);
        #1 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
        count_busy(n);
        compare("rst_mid_clear_len", n, 32'd16);

        repeat (3000) begin
            add_a = ADDR_W'($urandom_range(0, 31));
            add_b = ($urandom_range(0, 3) == 0) ? add_a : ADDR_W'($urandom_range(0, 31));
            add_dest = ($urandom_range(0, 2) == 0) ? add_a : ADDR_W'($urandom_range(0, 31));
            write_data = $urandom;
            write_en = 1'($urandom_range(0, 1));
            clear_req = ($urandom_range(0, 63) == 0);
            rst = ($urandom_range(0, 499) == 0);
            @(negedge clk);
            #1;
        end
        rst = 1'b0;
        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/banco_registros_param.md
# banco_registros_param

Parametrised register file for the RISC-V core: two registered read ports and one write port. Register 0 is hardwired to zero, and a write to a register being read in the same cycle is forwarded to the output. A built-in clear sequencer initialises the array after reset, or on request, one entry per cycle. It sits between decode (read addresses) and writeback (destination, data, enable).

## Interface

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width
- NUM_REGS, 32, number of implemented registers (2 ≤ NUM_REGS ≤ 2^ADDR_W)
- INIT_INDEX, 0, clear pattern: 0 writes zero to every entry; 1 writes each entry's own index, zero-extended to DATA_W

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset; asynchronous and active-high
- Add_A  in  ADDR_W  read address, port A
- Add_B  in  ADDR_W  read address, port B
- Add_Dest  in  ADDR_W  write address
- Write_Data  in  DATA_W  write data
- Write_En  in  1  write enable
- Clear_Req  in  1  re-run the clear sequence (sampled only in RUN)
- Info_A  out  DATA_W  registered read data, port A
- Info_B  out  DATA_W  registered read data, port B
- Busy  out  1  high while the clear sequence is running

## Operation

- Two-state FSM:
  - CLEAR: Busy=1.
  - RUN: Busy=0.
- RST asserted (asynchronous):
  - state=CLEAR, clear pointer=0, Info_A=0, Info_B=0, Busy=1.
  - Array contents are not reset directly.
- CLEAR behaviour:
  - Each edge writes the INIT pattern to entry[ptr], then ptr increments.
  - When ptr=NUM_REGS-1 the write happens and state→RUN on the same edge.
  - Info_A and Info_B are forced to 0; Write_En and Clear_Req are ignored (writes dropped, not queued).
- RUN, on each edge:
  - Clear_Req=1 → state=CLEAR, ptr=0. Any write in the same cycle is dropped. Info outputs update normally on that edge.
  - Write: if Write_En=1, Add_Dest≠0 and Add_Dest<NUM_REGS, then entry[Add_Dest] ← Write_Data.
  - Read A: Info_A ← 0 if Add_A=0 or Add_A≥NUM_REGS.
  - Bypass A: otherwise, if the write above is active with Add_Dest=Add_A, Info_A ← Write_Data.
  - Plain read A: otherwise Info_A ← entry[Add_A].
  - Port B follows the same rules independently, using Add_B.
- Entry 0 is never read as non-zero. With INIT_INDEX=1, entry 0 is still written with 0.
- Writes to addresses ≥NUM_REGS are silently ignored.

## Timing

- Read latency: 1 cycle. Address presented in cycle n → data valid after edge n+1.
- Write-to-read:
  - Same cycle: the bypass returns the new data after the same edge.
  - Any later cycle: the array returns the new data.
- Clear duration: exactly NUM_REGS edges after RST deassertion. Busy falls after the NUM_REGS-th edge. The first accepted write is in the following cycle.
- Clear_Req in RUN: Busy rises after that edge and stays high for NUM_REGS cycles.
- RST mid-clear: the sequence restarts from ptr=0 and the full NUM_REGS cycles are required again. Entries already cleared are simply rewritten.
- Simultaneous Add_A=Add_B=Add_Dest with a write active: both ports return Write_Data.
- Outputs change only on a CLK edge or on RST assertion. There are no combinational input-to-output paths.

## Test plan

- Reset/clear, INIT_INDEX=1, NUM_REGS=32: pulse RST, then read entry 5 once Busy=0.
  - Busy=1 for exactly 32 edges; Info_A/Info_B=0 throughout.
  - The later read gives Info_A=5; a read of entry 0 gives 0.
- x0 protection: in RUN, write 0xDEADBEEF to address 0, then read address 0 on both ports → Info_A=Info_B=0.
- Bypass: in the same cycle, Write_En=1, Add_Dest=7, Write_Data=0x12345678, Add_A=Add_B=7 → both outputs 0x12345678 after that edge; a read of 7 the next cycle is also 0x12345678.
- Write during clear: a write of 0xAA to entry 3 while Busy=1 is dropped; after Busy=0, a read of 3 gives 0 (INIT_INDEX=0) or 3 (INIT_INDEX=1).
- Clear_Req and out-of-range:
  - With NUM_REGS=16 and ADDR_W=5, a write to 20 is ignored and a read of 20 returns 0.
  - Asserting Clear_Req drives Busy high for 16 cycles; afterwards entry 9 reads 0 (INIT_INDEX=0).
- Reset mid-clear: assert RST at cycle 10 of the clear → the sequence restarts and Busy stays high for a further full NUM_REGS edges after deassertion.
